// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory controller: single-cycle
// stores, fixed-latency loads, and rejection of illegal requests.
module data_mem_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [3:0]        xfer_size,
  input  logic [63:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic              ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              wr_done,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              err_q, err_d;

  logic [7:0] mem [DEPTH];

  logic              req;
  logic              size_ok;
  logic              align_ok;
  logic              range_ok;
  logic              legal;
  logic              st_acc;
  logic              ld_acc;
  logic [AW-1:0]     base;
  logic [64:0]       end_addr;
  logic [DATA_W-1:0] mem_rd;

  assign ready    = (state_q == IDLE) & ~reset;
  assign rd_valid = (state_q == RESP);
  assign read_data = rdata_q;
  assign wr_done  = wr_done_q;
  assign err      = err_q;

  assign base     = address[AW-1:0];
  assign end_addr = {1'b0, address} + {61'd0, xfer_size};

  always_comb begin
    size_ok = 1'b0;
    case (xfer_size)
      4'd1, 4'd2, 4'd4: size_ok = 1'b1;
      4'd8:             size_ok = (NB == 8);
      default:          size_ok = 1'b0;
    endcase
  end

  // Size 8 wraps to mask 3'b111 in the low three bits.
  assign align_ok = (address[2:0] & (xfer_size[2:0] - 3'd1)) == 3'd0;
  assign range_ok = end_addr <= 65'(DEPTH);
  assign legal    = size_ok & align_ok & range_ok
                  & ~(mem_read & mem_write);

  assign req    = ready & (mem_read | mem_write);
  assign st_acc = req & legal & mem_write;
  assign ld_acc = req & legal & mem_read;

  always_comb begin
    mem_rd = '0;
    for (int b = 0; b < NB; b++) begin
      if (4'(b) < xfer_size)
        mem_rd[8*b +: 8] = mem[base + AW'(b)];
    end
  end

  always_ff @(posedge clk) begin
    if (st_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (4'(b) < xfer_size)
          mem[base + AW'(b)] <= write_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !legal)
          err_d = 1'b1;
        if (st_acc)
          wr_done_d = 1'b1;
        if (ld_acc) begin
          buf_d = mem_rd;
          cnt_d = LAT_M1;
          if (RD_LAT == 1) begin
            state_d = RESP;
            rdata_d = mem_rd;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          rdata_d = buf_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      buf_q     <= '0;
      rdata_q   <= '0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      rdata_q   <= rdata_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two configurations share one stimulus stream
// and are checked every cycle against a transaction-level model.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [3:0]  xfer_size = 4'd0;
  logic [63:0] address = 64'd0;
  logic [63:0] write_data = 64'd0;

  logic        rdy0, rv0, wd0, er0;
  logic [63:0] rd0;
  logic        rdy1, rv1, wd1, er1;
  logic [31:0] rd1;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(64), .DEPTH(1024), .RD_LAT(2)) u0 (
    .clk(clk), .reset(reset), .mem_write(mem_write),
    .mem_read(mem_read), .xfer_size(xfer_size), .address(address),
    .write_data(write_data), .ready(rdy0), .rd_valid(rv0),
    .read_data(rd0), .wr_done(wd0), .err(er0)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .mem_write(mem_write),
    .mem_read(mem_read), .xfer_size(xfer_size), .address(address),
    .write_data(write_data[31:0]), .ready(rdy1), .rd_valid(rv1),
    .read_data(rd1), .wr_done(wd1), .err(er1)
  );

  logic        o_rdy [2];
  logic        o_rv  [2];
  logic        o_wd  [2];
  logic        o_er  [2];
  logic [63:0] o_rd  [2];

  always_comb begin
    o_rdy[0] = rdy0; o_rv[0] = rv0; o_wd[0] = wd0;
    o_er[0]  = er0;  o_rd[0] = rd0;
    o_rdy[1] = rdy1; o_rv[1] = rv1; o_wd[1] = wd1;
    o_er[1]  = er1;  o_rd[1] = {32'd0, rd1};
  end

  function automatic int nb(input int k);
    return (k == 0) ? 8 : 4;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic longint unsigned dp(input int k);
    return (k == 0) ? 1024 : 256;
  endfunction

  // Model: byte arrays, cycles-until-idle counter, pending load value.
  logic [7:0]  mm [2][1024];
  int          left [2] = '{0, 0};
  bit          e_rv [2] = '{0, 0};
  bit          e_wd [2] = '{0, 0};
  bit          e_er [2] = '{0, 0};
  logic [63:0] e_rd [2] = '{64'd0, 64'd0};
  logic [63:0] pend [2] = '{64'd0, 64'd0};
  bit          idle_m;

  function automatic bit legal(input int k);
    int sz;
    longint unsigned a;
    sz = int'(xfer_size);
    a  = address;
    if (mem_read && mem_write) return 1'b0;
    if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) return 1'b0;
    if (sz > nb(k)) return 1'b0;
    if (a % longint'(sz) != 0) return 1'b0;
    if (a > dp(k) - longint'(sz)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        left[k] = 0;
        e_rv[k] = 0; e_wd[k] = 0; e_er[k] = 0;
        e_rd[k] = 64'd0;
      end else begin
        idle_m = (left[k] == 0);
        e_rv[k] = 0; e_wd[k] = 0; e_er[k] = 0;
        if (left[k] > 0) left[k] = left[k] - 1;
        if (idle_m && (mem_read || mem_write)) begin
          if (!legal(k)) begin
            e_er[k] = 1;
          end else if (mem_write) begin
            for (int b = 0; b < int'(xfer_size); b++)
              mm[k][int'(address[15:0]) + b] = write_data[8*b +: 8];
            e_wd[k] = 1;
          end else begin
            pend[k] = 64'd0;
            for (int b = 0; b < int'(xfer_size); b++)
              pend[k][8*b +: 8] = mm[k][int'(address[15:0]) + b];
            left[k] = lat(k);
          end
        end
        if (left[k] == 1) begin
          e_rv[k] = 1;
          e_rd[k] = pend[k];
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s dut%0d @%0t: got %h, expected %h",
                 nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("ready", k, 64'(o_rdy[k]), 64'(!reset && left[k] == 0));
      chk("rd_valid", k, 64'(o_rv[k]), 64'(e_rv[k]));
      chk("wr_done", k, 64'(o_wd[k]), 64'(e_wd[k]));
      chk("err", k, 64'(o_er[k]), 64'(e_er[k]));
      chk("read_data", k, o_rd[k], e_rd[k]);
    end
  end

  // One request for one cycle, then observe dut k for six cycles.
  task automatic run(input logic r, input logic w, input int sz,
                     input logic [63:0] a, input logic [63:0] d,
                     input int k, output int rv_at,
                     output logic [63:0] rdat, output int n_er,
                     output int n_wd, output int n_rv, output int n_nr);
    mem_read = r; mem_write = w; xfer_size = 4'(sz);
    address = a; write_data = d;
    rv_at = 0; rdat = 64'd0; n_er = 0; n_wd = 0; n_rv = 0; n_nr = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (o_rv[k]) begin
        n_rv++;
        if (rv_at == 0) rv_at = i;
        rdat = o_rd[k];
      end
      if (o_er[k]) n_er++;
      if (o_wd[k]) n_wd++;
      if (!o_rdy[k]) n_nr++;
      if (i == 1) begin
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    int rv_at, n_er, n_wd, n_rv, n_nr, cnt, sz, r, lim;
    logic [63:0] rdat, a;

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 0, 64'(o_rdy[0]), 64'd1);
    chk("rst_rv", 0, 64'(o_rv[0]), 64'd0);
    chk("rst_rdata", 0, o_rd[0], 64'd0);
    #1;

    for (int i = 0; i < 1024; i += 4) begin
      mem_write = 1'b1; xfer_size = 4'd4;
      address = 64'(i); write_data = {$urandom, $urandom};
      @(negedge clk); #1;
    end
    mem_write = 1'b0;
    @(negedge clk); #1;

    run(0, 1, 8, 64'h80, 64'h0123456789ABCDEF, 0,
        rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("st8_wd", 0, 64'(n_wd), 64'd1);
    chk("st8_err", 0, 64'(n_er), 64'd0);
    run(1, 0, 8, 64'h80, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("ld8_lat", 0, 64'(rv_at), 64'd2);
    chk("ld8_data", 0, rdat, 64'h0123456789ABCDEF);
    chk("ld8_notready", 0, 64'(n_nr), 64'd2);
    run(1, 0, 1, 64'h81, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("ld1_data", 0, rdat, 64'hCD);
    run(1, 0, 2, 64'h82, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("ld2_data", 0, rdat, 64'h89AB);
    run(1, 0, 4, 64'h82, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("misal_err", 0, 64'(n_er), 64'd1);
    chk("misal_rv", 0, 64'(n_rv), 64'd0);
    run(1, 0, 3, 64'h80, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("sz3_err", 0, 64'(n_er), 64'd1);
    run(1, 1, 8, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 0,
        rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("both_err", 0, 64'(n_er), 64'd1);
    chk("both_rv", 0, 64'(n_rv + n_wd), 64'd0);
    run(1, 0, 8, 64'h80, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("unchanged", 0, rdat, 64'h0123456789ABCDEF);
    run(0, 1, 8, 64'd1016, 64'h5555_AAAA_1234_8765, 0,
        rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("top_st_wd", 0, 64'(n_wd), 64'd1);
    run(0, 1, 8, 64'd1020, 64'd7, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("over_st_err", 0, 64'(n_er), 64'd1);
    run(0, 1, 1, 64'd1024, 64'd7, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("past_end_err", 0, 64'(n_er), 64'd1);

    mem_read = 1'b1; xfer_size = 4'd8; address = 64'h80;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (o_rv[0]) cnt++;
      if (i == 2) begin
        #1 mem_read = 1'b0;
      end
    end
    chk("busy_ignored", 0, 64'(cnt), 64'd1);
    #1;

    mem_read = 1'b1; xfer_size = 4'd8; address = 64'h80;
    @(negedge clk);
    #1 mem_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 0, 64'(o_rdy[0]), 64'd0);
    chk("rst_mid_rv", 0, 64'(o_rv[0]), 64'd0);
    chk("rst_mid_rdata", 0, o_rd[0], 64'd0);
    #1 reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_rv[0]) cnt++;
    end
    chk("abort_no_rv", 0, 64'(cnt), 64'd0);
    #1;
    run(1, 0, 8, 64'h80, 64'd0, 0, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("post_rst_data", 0, rdat, 64'h0123456789ABCDEF);

    run(0, 1, 8, 64'h40, 64'd1, 1, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("w32_sz8_err", 1, 64'(n_er), 64'd1);
    run(0, 1, 4, 64'h40, 64'hDEADBEEF, 1,
        rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("w32_st_wd", 1, 64'(n_wd), 64'd1);
    run(1, 0, 4, 64'h40, 64'd0, 1, rv_at, rdat, n_er, n_wd, n_rv, n_nr);
    chk("w32_lat", 1, 64'(rv_at), 64'd1);
    chk("w32_data", 1, rdat, 64'hDEADBEEF);
    chk("w32_notready", 1, 64'(n_nr), 64'd1);

    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        reset = 1'b0;
        r = $urandom_range(0, 9);
        mem_read  = (r < 4) || (r == 8);
        mem_write = (r >= 4 && r < 8) || (r == 8);
        if ($urandom_range(0, 15) == 0) sz = $urandom_range(0, 15);
        else sz = 1 << $urandom_range(0, 3);
        lim = $urandom_range(0, 1) ? 255 : 1023;
        r = $urandom_range(0, 31);
        if (r == 0) a = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (r < 3) a = 64'(($urandom_range(0, 1) ? 1024 : 256)
                               - 8 + $urandom_range(0, 15));
        else if (r < 6) a = 64'($urandom_range(0, lim));
        else a = 64'($urandom_range(0, lim) & ~(sz - 1));
        xfer_size = 4'(sz); address = a;
        write_data = {$urandom, $urandom};
      end
      @(negedge clk); #1;
    end
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
